ddr_arbiter: RTL and testbench
==============================

// Module: ddr_arbiter
// PURPOSE
//   Shares the single ddr_ctrl CPU-side port between the instruction cache (read-only) and the
//   data cache (read/write). Grants one requester at a time and sequences each 256-bit block
//   transfer as two 128-bit beats: low half (addr[2]=0), then high half (addr[2]=1).
//   Returns the whole block and a one-cycle ready pulse. Runs in the ui_clk domain of ddr_ctrl.
// PARAMETERS
//   ADDR_W   30     word (4-byte) address width, matches ddr_ctrl ram_addr
//   BLOCK_W  256    block width, two beats of BLOCK_W/2
//   RR_EN    1      1: round-robin on simultaneous requests; 0: fixed dcache priority
//   TMO_CYC  4096   cycles in one beat wait before sticky timeout flag sets
// PORTS
//   clk        in   1        ui_clk from ddr_ctrl; all logic on posedge
//   rst        in   1        asynchronous, active-low reset
//   i_en       in   1        icache block read request, held until i_rdy
//   i_addr     in   ADDR_W   icache word address; bits [2:0] ignored
//   i_rdy      out  1        one-cycle pulse: i_block valid
//   i_block    out  BLOCK_W  last block read for icache
//   d_en       in   1        dcache request, held until d_rdy
//   d_write    in   1        1 = block write, 0 = block read
//   d_addr     in   ADDR_W   dcache word address; bits [2:0] ignored
//   d_wdata    in   BLOCK_W  write block
//   d_rdy      out  1        one-cycle pulse: transaction complete
//   d_block    out  BLOCK_W  last block read for dcache (unchanged by writes)
//   ram_en     out  1        to ddr_ctrl ram_en
//   ram_write  out  1        to ddr_ctrl ram_write
//   ram_addr   out  ADDR_W   to ddr_ctrl ram_addr
//   ram_wdata  out  BLOCK_W  to ddr_ctrl data_to_ram (full block both beats)
//   ram_rdy    in   1        from ddr_ctrl ram_rdy (combinational, drops on addr/op change)
//   ram_block  in   BLOCK_W  from ddr_ctrl block_out
//   gnt        out  2        current owner: 00 none, 01 icache, 10 dcache
//   tmo_err    out  1        sticky timeout flag
// BEHAVIOUR
//   Reset (async, rst=0): state IDLE. All outputs 0. Last-grant = icache, so the first tie
//   goes to dcache. The arbiter does not abort ddr_ctrl; both blocks share rst.
//   States: IDLE -> B0 -> B1 -> RESP -> IDLE. All outputs are registered.
//   IDLE: i_en/d_en sampled. Tie: RR_EN=1 grants the one not granted last; RR_EN=0 grants
//     dcache. On grant, latch addr/write/wdata, set gnt, and go to B0. Requester input
//     changes after grant are ignored. Dropping en before rdy does not abort.
//   B0: ram_en=1, ram_addr={addr[ADDR_W-1:3],3'b000}, ram_write=latched (0 for icache).
//     ram_rdy is ignored in the first B0 cycle (address just changed). In later cycles,
//     ram_rdy=1 moves to B1.
//   B1: same, with ram_addr={addr[ADDR_W-1:3],3'b100}. First-cycle ignore rule applies.
//     ram_rdy=1 on a read latches ram_block into i_block/d_block per owner, then RESP.
//   RESP: ram_en=0. Owner rdy=1 for exactly this cycle, gnt=00, update last-grant, then IDLE.
//     The requester must drop en, or present a new request, by the next IDLE cycle.
//   Because every transaction ends on a high-half address and starts on a low half,
//   ddr_ctrl's last-address check never suppresses an access, including repeated
//   writes to the same block.
//   Latency: minimum 5 cycles from en sampled in IDLE to the rdy pulse. Throughput is one
//     block per 6 cycles minimum.
//   Timeout: a counter clears on entry to B0/B1 and increments while waiting. At TMO_CYC
//     it sets tmo_err, which stays set until reset. The transaction keeps waiting.
//   Reset mid-transaction: immediate IDLE. No rdy pulse. Blocks clear to 0.
// TESTING
//   1 icache read 0x100, ddr_ctrl model rdy after 3 cycles per beat -> ram_addr 0x100 then
//     0x104, i_rdy single pulse, i_block = model data, d_rdy stays 0.
//   2 dcache write 0x200 data A -> two beats ram_write=1, addrs 0x200/0x204, ram_wdata=A,
//     d_rdy pulse, d_block unchanged. Repeat with data B -> both beats issued again.
//   3 i_en and d_en same cycle, RR_EN=1, three back-to-back rounds -> grants D,I,D,I,D,I;
//     with RR_EN=0 -> D,D,D before any I.
//   4 model ram_rdy held 1 constantly -> beat advances only after the ignore cycle, rdy at
//     exactly 5 cycles.
//   5 model never asserts ram_rdy, TMO_CYC=16 -> tmo_err rises after 16 wait cycles, ram_en
//     stays 1, no rdy.
//   6 rst low during B1 -> ram_en, gnt, rdy, blocks all 0 immediately. Next request starts
//     fresh at B0.

Source files
------------

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the ddr_ctrl CPU port between icache and dcache.
// Each block moves as two half-block beats, low half then high half.
module ddr_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int BLOCK_W = 256,
  parameter int RR_EN   = 1,
  parameter int TMO_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_rdy,
  output logic [BLOCK_W-1:0] i_block,
  input  logic               d_en,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_rdy,
  output logic [BLOCK_W-1:0] d_block,
  output logic               ram_en,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [BLOCK_W-1:0] ram_wdata,
  input  logic               ram_rdy,
  input  logic [BLOCK_W-1:0] ram_block,
  output logic [1:0]         gnt,
  output logic               tmo_err
);

  localparam int AW = ADDR_W - 3;
  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TMO_CYC);

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    RESP
  } state_t;

  state_t state, state_d;

  logic               own_q, own_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic               last_q, last_d;
  logic               first_q, first_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tmo_d;
  logic [BLOCK_W-1:0] iblk_d, dblk_d;
  logic               ram_en_d, ram_write_d;
  logic [ADDR_W-1:0]  ram_addr_d;
  logic [1:0]         gnt_d;
  logic               i_rdy_d, d_rdy_d;
  logic               act_d, waiting;
  logic               pick_d, adv;

  logic unused;
  assign unused = ^{i_addr[2:0], d_addr[2:0]};

  // dcache wins unless icache also asks and dcache had the last grant
  assign pick_d = d_en & (~i_en | (RR_EN == 0) | ~last_q);
  assign adv    = ~first_q & ram_rdy;

  // next state, latched request and next registered outputs
  always_comb begin
    state_d = state;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    tmo_d   = tmo_err;
    iblk_d  = i_block;
    dblk_d  = d_block;
    waiting = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_en | d_en) begin
          state_d = B0;
          own_d   = pick_d;
          wr_d    = pick_d & d_write;
          addr_d  = pick_d ? d_addr[ADDR_W-1:3]
                           : i_addr[ADDR_W-1:3];
          wdata_d = pick_d ? d_wdata : '0;
          first_d = 1'b1;
          cnt_d   = '0;
        end
      end
      B0: begin
        if (adv) begin
          state_d = B1;
          first_d = 1'b1;
          cnt_d   = '0;
        end else begin
          waiting = 1'b1;
        end
      end
      B1: begin
        if (adv) begin
          state_d = RESP;
          if (!wr_q) begin
            if (own_q) dblk_d = ram_block;
            else       iblk_d = ram_block;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = own_q;
      end
      default: state_d = IDLE;
    endcase
    if (waiting) begin
      if (cnt_q != TMO_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMO_LAST) tmo_d = 1'b1;
    end
    act_d       = (state_d == B0) | (state_d == B1);
    ram_en_d    = act_d;
    ram_write_d = act_d & wr_d;
    ram_addr_d  = act_d ? {addr_d, state_d == B1, 2'b00} : '0;
    gnt_d       = act_d ? (own_d ? 2'b10 : 2'b01) : 2'b00;
    i_rdy_d     = (state_d == RESP) & ~own_d;
    d_rdy_d     = (state_d == RESP) & own_d;
  end

  // state, request latches and all outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      tmo_err   <= 1'b0;
      i_block   <= '0;
      d_block   <= '0;
      ram_en    <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      gnt       <= 2'b00;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
    end else begin
      state     <= state_d;
      own_q     <= own_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      tmo_err   <= tmo_d;
      i_block   <= iblk_d;
      d_block   <= dblk_d;
      ram_en    <= ram_en_d;
      ram_write <= ram_write_d;
      ram_addr  <= ram_addr_d;
      gnt       <= gnt_d;
      i_rdy     <= i_rdy_d;
      d_rdy     <= d_rdy_d;
    end
  end

  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: scoreboard bench for ddr_arbiter.
// Model ddr_ctrl answers per beat; responses and beats checked per owner.
module tb_ddr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         i_en = 0, i_rdy;
  logic [29:0]  i_addr = '0;
  logic [255:0] i_block;
  logic         d_en = 0, d_write = 0, d_rdy;
  logic [29:0]  d_addr = '0;
  logic [255:0] d_wdata = '0, d_block;
  logic         ram_en, ram_write, ram_rdy;
  logic [29:0]  ram_addr;
  logic [255:0] ram_wdata, ram_block;
  logic [1:0]   gnt;
  logic         tmo_err;

  ddr_arbiter #(.ADDR_W(30), .BLOCK_W(256), .RR_EN(1), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_addr(i_addr), .i_rdy(i_rdy), .i_block(i_block),
    .d_en(d_en), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_block(d_block),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdy(ram_rdy), .ram_block(ram_block),
    .gnt(gnt), .tmo_err(tmo_err)
  );

  logic         i_en_b = 0, i_rdy_b, d_en_b = 0, d_rdy_b;
  logic [255:0] i_block_b, d_block_b, ram_wdata_b;
  logic         ram_en_b, ram_write_b, tmo_err_b;
  logic [29:0]  ram_addr_b;
  logic [1:0]   gnt_b;

  ddr_arbiter #(.ADDR_W(30), .BLOCK_W(256), .RR_EN(0), .TMO_CYC(16)) dut_b (
    .clk(clk), .rst(rst),
    .i_en(i_en_b), .i_addr(30'h40), .i_rdy(i_rdy_b), .i_block(i_block_b),
    .d_en(d_en_b), .d_write(1'b0), .d_addr(30'h80), .d_wdata('0),
    .d_rdy(d_rdy_b), .d_block(d_block_b),
    .ram_en(ram_en_b), .ram_write(ram_write_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_rdy(ram_en_b), .ram_block('0),
    .gnt(gnt_b), .tmo_err(tmo_err_b)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [255:0] mdl(input logic [29:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++)
      r[k*32 +: 32] = {2'b00, a} ^ (32'h5A5A_0000 + 32'(k) * 32'h0101_0101);
    return r;
  endfunction

  // ddr_ctrl model: 0 = ready 3 cycles after addr settles, 1 = always, 2 = never
  logic [1:0]  mode = 2'd0;
  logic [29:0] maddr = '0;
  int          mcnt = 0;
  always @(posedge clk) begin
    if (ram_en && ram_addr == maddr) mcnt <= mcnt + 1;
    else mcnt <= 0;
    maddr <= ram_addr;
  end
  assign ram_rdy = ram_en && (mode == 2'd1 ||
                   (mode == 2'd0 && ram_addr == maddr && mcnt >= 2));
  assign ram_block = mdl(ram_addr);

  typedef struct {
    logic [29:0]  a;
    logic         w;
    logic [255:0] wd;
  } beat_t;

  logic [255:0] iq[$], dq[$];
  beat_t        ibq[$], dbq[$];
  bit           glog[$];
  logic [255:0] exp_iblk = '0, exp_dblk = '0;
  int           icnt = 0, dcnt = 0, dbeats = 0;

  // response and beat monitor
  initial begin
    logic        pen, pir, pdr;
    logic [29:0] paddr;
    beat_t       eb;
    logic [255:0] ev;
    pen = 0; pir = 0; pdr = 0; paddr = '0;
    forever begin
      @(negedge clk);
      if (ram_en && (!pen || ram_addr != paddr)) begin
        tests++;
        if (gnt == 2'b10) dbeats++;
        if (gnt == 2'b01 && ibq.size() > 0) eb = ibq.pop_front();
        else if (gnt == 2'b10 && dbq.size() > 0) eb = dbq.pop_front();
        else begin
          eb.a = '1; eb.w = 1'b1; eb.wd = '1;
        end
        if (ram_addr !== eb.a || ram_write !== eb.w ||
            (eb.w && ram_wdata !== eb.wd)) begin
          fails++;
          $display("FAIL beat: addr %h wr %b gnt %b, required addr %h wr %b",
                   ram_addr, ram_write, gnt, eb.a, eb.w);
        end
      end
      pen = ram_en;
      paddr = ram_addr;
      if (i_rdy) begin
        tests++;
        icnt++;
        glog.push_back(1'b0);
        ev = (iq.size() > 0) ? iq.pop_front() : ~i_block;
        if (i_block !== ev || pir || gnt !== 2'b00) begin
          fails++;
          $display("FAIL i_resp: block %h gnt %b, required %h gnt 00",
                   i_block, gnt, ev);
        end
      end
      if (d_rdy) begin
        tests++;
        dcnt++;
        glog.push_back(1'b1);
        ev = (dq.size() > 0) ? dq.pop_front() : ~d_block;
        if (d_block !== ev || pdr || gnt !== 2'b00) begin
          fails++;
          $display("FAIL d_resp: block %h gnt %b, required %h gnt 00",
                   d_block, gnt, ev);
        end
      end
      pir = i_rdy;
      pdr = d_rdy;
    end
  end

  task automatic push_exp(input bit isd, input bit we,
                          input logic [29:0] a, input logic [255:0] wd,
                          input bit resp);
    beat_t b;
    b.w = we;
    b.wd = wd;
    b.a = {a[29:3], 3'b000};
    if (isd) dbq.push_back(b); else ibq.push_back(b);
    b.a = {a[29:3], 3'b100};
    if (isd) dbq.push_back(b); else ibq.push_back(b);
    if (!resp) return;
    if (isd) begin
      if (!we) exp_dblk = mdl(b.a);
      dq.push_back(exp_dblk);
    end else begin
      exp_iblk = mdl(b.a);
      iq.push_back(exp_iblk);
    end
  endtask

  task automatic run_req(input bit isd, input bit we,
                         input logic [29:0] a, input logic [255:0] wd,
                         output int lat);
    @(negedge clk);
    push_exp(isd, we, a, wd, 1'b1);
    if (isd) begin
      d_en = 1; d_write = we; d_addr = a; d_wdata = wd;
    end else begin
      i_en = 1; i_addr = a;
    end
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (isd ? d_rdy : i_rdy) begin
        lat = c;
        break;
      end
    end
    if (isd) d_en = 0; else i_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    i_en = 0; d_en = 0; i_en_b = 0; d_en_b = 0;
    @(negedge clk);
    iq.delete(); dq.delete(); ibq.delete(); dbq.delete();
    exp_iblk = '0; exp_dblk = '0;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ram_en, ram_write, gnt, i_rdy, d_rdy, tmo_err} !== 7'd0 ||
        ram_addr !== '0 || ram_wdata !== '0) begin
      fails++;
      $display("FAIL reset_ctl: en %b wr %b gnt %b addr %h, required all 0",
               ram_en, ram_write, gnt, ram_addr);
    end
    tests++;
    if (i_block !== '0 || d_block !== '0) begin
      fails++;
      $display("FAIL reset_blk: i %h d %h, required 0", i_block, d_block);
    end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_icache_read();
    int lat, d0;
    mode = 2'd0;
    d0 = dcnt;
    run_req(1'b0, 1'b0, 30'h100, '0, lat);
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL i_read_done: no i_rdy, required a pulse");
    end
    repeat (3) @(negedge clk);
    tests++;
    if (dcnt != d0) begin
      fails++;
      $display("FAIL i_read_drdy: %0d d_rdy pulses, required 0", dcnt - d0);
    end
  endtask

  task automatic test_dcache_write();
    int lat, b0;
    logic [255:0] da, db;
    da = {8{32'hAAAA_5555}};
    db = {8{32'h1234_ABCD}};
    mode = 2'd0;
    run_req(1'b1, 1'b0, 30'h180, '0, lat);
    b0 = dbeats;
    run_req(1'b1, 1'b1, 30'h200, da, lat);
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL d_write_a: no d_rdy, required a pulse");
    end
    run_req(1'b1, 1'b1, 30'h200, db, lat);
    tests++;
    if (lat < 0 || dbeats - b0 != 4) begin
      fails++;
      $display("FAIL d_write_b: lat %0d beats %0d, required done and 4",
               lat, dbeats - b0);
    end
  endtask

  task automatic test_round_robin();
    bit exp_g[6];
    exp_g = '{1, 0, 1, 0, 1, 0};
    do_reset();
    mode = 2'd1;
    @(negedge clk);
    glog.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          bit ok;
          push_exp(1'b0, 1'b0, 30'h1000 + 30'(k * 8), '0, 1'b1);
          i_addr = 30'h1000 + 30'(k * 8);
          i_en = 1;
          ok = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (i_rdy) begin ok = 1; break; end
          end
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL rr_i_wait: round %0d no i_rdy", k);
          end
        end
        i_en = 0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          bit ok;
          push_exp(1'b1, 1'b0, 30'h2000 + 30'(k * 8), '0, 1'b1);
          d_addr = 30'h2000 + 30'(k * 8);
          d_write = 0;
          d_en = 1;
          ok = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (d_rdy) begin ok = 1; break; end
          end
          tests++;
          if (!ok) begin
            fails++;
            $display("FAIL rr_d_wait: round %0d no d_rdy", k);
          end
        end
        d_en = 0;
      end
    join
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (k >= glog.size() || glog[k] !== exp_g[k]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d (log size %0d), required %0d",
                 k, (k < glog.size()) ? int'(glog[k]) : -1,
                 glog.size(), exp_g[k]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    bit lg[$];
    int nd;
    @(negedge clk);
    i_en_b = 1;
    d_en_b = 1;
    nd = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (d_rdy_b) begin
        lg.push_back(1'b1);
        nd++;
        if (nd == 3) d_en_b = 0;
      end
      if (i_rdy_b) begin
        lg.push_back(1'b0);
        break;
      end
    end
    i_en_b = 0;
    d_en_b = 0;
    tests++;
    if (lg.size() != 4 || lg[0] !== 1 || lg[1] !== 1 ||
        lg[2] !== 1 || lg[3] !== 0) begin
      fails++;
      $display("FAIL fixed_prio: %0d grants, required D,D,D,I", lg.size());
    end
  endtask

  task automatic test_ready_latency();
    int lat;
    mode = 2'd1;
    run_req(1'b0, 1'b0, 30'h300, '0, lat);
    tests++;
    if (lat != 5) begin
      fails++;
      $display("FAIL lat_i: %0d cycles, required 5", lat);
    end
    run_req(1'b1, 1'b0, 30'h408, '0, lat);
    tests++;
    if (lat != 5) begin
      fails++;
      $display("FAIL lat_d: %0d cycles, required 5", lat);
    end
  endtask

  task automatic test_timeout();
    int i0;
    beat_t b;
    mode = 2'd2;
    i0 = icnt;
    @(negedge clk);
    b.a = 30'h500; b.w = 0; b.wd = '0;
    ibq.push_back(b);
    i_addr = 30'h500;
    i_en = 1;
    repeat (15) @(negedge clk);
    tests++;
    if (tmo_err !== 1'b0 || ram_en !== 1'b1) begin
      fails++;
      $display("FAIL tmo_early: tmo %b ram_en %b, required 0 1",
               tmo_err, ram_en);
    end
    i_en = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (tmo_err !== 1'b1 || ram_en !== 1'b1 || gnt !== 2'b01 || icnt != i0) begin
      fails++;
      $display("FAIL tmo_set: tmo %b ram_en %b gnt %b rdy %0d, required 1 1 01 0",
               tmo_err, ram_en, gnt, icnt - i0);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit hit;
    do_reset();
    mode = 2'd0;
    run_req(1'b0, 1'b0, 30'h700, '0, lat);
    run_req(1'b1, 1'b0, 30'h708, '0, lat);
    @(negedge clk);
    push_exp(1'b0, 1'b0, 30'h600, '0, 1'b0);
    i_addr = 30'h600;
    i_en = 1;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ram_en && ram_addr[2]) begin hit = 1; break; end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_b1: never reached high beat");
    end
    rst = 0;
    i_en = 0;
    #1;
    tests++;
    if ({ram_en, gnt, i_rdy, d_rdy, tmo_err} !== 6'd0 ||
        i_block !== '0 || d_block !== '0) begin
      fails++;
      $display("FAIL mid_rst: en %b gnt %b rdy %b%b blk %h/%h, required 0",
               ram_en, gnt, i_rdy, d_rdy, i_block, d_block);
    end
    @(negedge clk);
    iq.delete(); dq.delete(); ibq.delete(); dbq.delete();
    exp_iblk = '0; exp_dblk = '0;
    rst = 1;
    run_req(1'b0, 1'b0, 30'h800, '0, lat);
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL mid_fresh: no i_rdy after reset, required a pulse");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_round_robin();
    test_fixed_priority();
    test_ready_latency();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (iq.size() + dq.size() + ibq.size() + dbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d resp %0d/%0d beats left, required 0",
               iq.size(), dq.size(), ibq.size(), dbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
